// File: rtl/microarch_defs.sv
// Shared execute-stage definitions: ALU op encodings, flag bit positions,
// issue sequencer state encoding and wait-counter width.
package microarch_defs;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    // Wide enough for the largest legal ALU latency (7).
    localparam int ISSUE_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_issue_wait_cnt.sv
// Loadable down-counter with zero indication, paces the ALU latency window.
// Latency: load/decrement take effect at the next clk edge.
// Backpressure: none; decrement saturates at zero.
module alu_issue_wait_cnt
    import microarch_defs::*;
#(
    parameter int W = ISSUE_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the registered 8-bit ALU; ALU_ISSUE_PERF_EN adds perf counters.
// Latency: response valid ALU_LAT+2 cycles after the accept cycle.
// Backpressure: req_ready low in WAIT, and in RESP until resp_ready; RESP->WAIT has no bubble.
module alu_issue_ctrl
    import microarch_defs::*;
#(
    parameter int ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,
    input  logic       alu_negative,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_result,
    output logic [2:0] resp_flags,
    output logic       busy
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0] perf_ops,
    output logic [15:0] perf_stall
`endif
);

    if (ALU_LAT < 1 || ALU_LAT > 7) begin : g_lat_check
        $error("alu_issue_ctrl: ALU_LAT must be in 1..7");
    end

    localparam logic [ISSUE_CNT_W-1:0] LAT_LOAD = ISSUE_CNT_W'(ALU_LAT);

    issue_state_t state;
    logic         accept;
    logic         cnt_zero;

    assign req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    alu_issue_wait_cnt #(.W(ISSUE_CNT_W)) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (LAT_LOAD),
        .dec      (state == WAIT),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= ALU_ADD;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
        end else begin
            // alu_* only change on accept so the ALU never sees stale/garbage inputs.
            if (accept) begin
                alu_a  <= req_a;
                alu_b  <= req_b;
                alu_op <= req_op;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_zero) begin
                        resp_result        <= alu_result;
                        resp_flags[FLAG_N] <= alu_negative;
                        resp_flags[FLAG_C] <= alu_carry;
                        resp_flags[FLAG_Z] <= alu_zero;
                        resp_valid         <= 1'b1;
                        state              <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= accept ? WAIT : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (resp_valid && resp_ready) begin
                perf_ops <= perf_ops + 16'd1;
            end
            if ((state == RESP) && !resp_ready) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a registered ALU model attached;
// expected responses come from an arithmetic reference of the op semantics.
module tb_alu_issue_ctrl;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_negative;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_result;
    logic [2:0] resp_flags;
    logic       busy;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] perf_ops;
    logic [15:0] perf_stall;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.ALU_LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_negative (alu_negative),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_flags   (resp_flags),
        .busy         (busy)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_ops     (perf_ops),
        .perf_stall   (perf_stall)
`endif
    );

    // Registered ALU: result/carry one cycle after inputs, zero/negative one more.
    always @(posedge clk) begin
        case (alu_op)
            2'b00:   {alu_carry, alu_result} <= {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   {alu_carry, alu_result} <= {1'b0, alu_a} - {1'b0, alu_b};
            2'b10:   {alu_carry, alu_result} <= {1'b0, alu_a & alu_b};
            default: {alu_carry, alu_result} <= {1'b0, alu_a | alu_b};
        endcase
        alu_zero     <= (alu_result == 8'h00);
        alu_negative <= alu_result[7];
    end

    // Reference: what the response must contain for a given op, flags as {N,C,Z}.
    task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic [2:0] flags);
        int r;
        logic c;
        c = 1'b0;
        case (op)
            2'd0: begin r = int'(a) + int'(b); c = (r > 255); end
            2'd1: begin r = int'(a) - int'(b); c = (r < 0); end
            2'd2: r = int'(a & b);
            default: r = int'(a | b);
        endcase
        res   = 8'(r & 255);
        flags = {res >= 8'd128, c, res == 8'd0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction: accept, hold check through WAIT, latency, result, optional stall.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int stall);
        logic [7:0] er;
        logic [2:0] ef;
        int n;
`ifdef ALU_ISSUE_PERF_EN
        logic [15:0] ops0, stall0;
`endif
        model(op, a, b, er, ef);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL accept_timeout: req_ready=%b want 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        // Garbage on the request bus must be ignored while WAIT/RESP-stalled.
        req_valid = 1'($urandom); req_op = 2'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
        n = 1;
        while (!resp_valid && n < 20) begin
            vectors++;
            if (alu_a !== a || alu_b !== b || alu_op !== op) begin
                miscompares++;
                $display("FAIL alu_hold: a=%h b=%h op=%0d want a=%h b=%h op=%0d", alu_a, alu_b, alu_op, a, b, op);
            end
            @(posedge clk); n++; @(negedge clk);
        end
        vectors++;
        if (n !== LAT + 2) begin
            miscompares++; $display("FAIL latency: %0d cycles want %0d", n, LAT + 2);
        end
        vectors++;
        if (resp_result !== er || resp_flags !== ef) begin
            miscompares++;
            $display("FAIL resp op=%0d a=%h b=%h: result=%h flags=%b want %h %b", op, a, b, resp_result, resp_flags, er, ef);
        end
`ifdef ALU_ISSUE_PERF_EN
        ops0 = perf_ops; stall0 = perf_stall;
`endif
        req_valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_result !== er || resp_flags !== ef) begin
                miscompares++;
                $display("FAIL stall_hold: rdy=%b vld=%b result=%h flags=%b want 0 1 %h %b", req_ready, resp_valid, resp_result, resp_flags, er, ef);
            end
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL handshake_idle: vld=%b busy=%b want 0 0", resp_valid, busy);
        end
`ifdef ALU_ISSUE_PERF_EN
        vectors++;
        if (perf_stall !== 16'(stall0 + 16'(stall)) || perf_ops !== 16'(ops0 + 16'd1)) begin
            miscompares++;
            $display("FAIL perf: stall=%0d ops=%0d want %0d %0d", perf_stall, perf_ops, 16'(stall0 + 16'(stall)), 16'(ops0 + 16'd1));
        end
`endif
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || alu_a !== 8'h00 ||
            alu_b !== 8'h00 || alu_op !== 2'b00 || resp_result !== 8'h00 || resp_flags !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_state: vld=%b busy=%b rdy=%b a=%h b=%h op=%0d res=%h fl=%b", resp_valid, busy, req_ready, alu_a, alu_b, alu_op, resp_result, resp_flags);
        end
`ifdef ALU_ISSUE_PERF_EN
        vectors++;
        if (perf_ops !== 16'd0 || perf_stall !== 16'd0) begin
            miscompares++; $display("FAIL reset_perf: ops=%0d stall=%0d want 0 0", perf_ops, perf_stall);
        end
`endif
    endtask

    task automatic test_directed();
        run_op(2'd0, 8'hF0, 8'h20, 0);
        run_op(2'd1, 8'h05, 8'h05, 0);
        run_op(2'd1, 8'h03, 8'h05, 0);
        run_op(2'd2, 8'hF0, 8'h0F, 0);
        run_op(2'd3, 8'h80, 8'h01, 0);
    endtask

    task automatic test_backpressure();
        run_op(2'd1, 8'h03, 8'h05, 5);
    endtask

    task automatic test_back_to_back();
        logic [7:0] er1, er2;
        logic [2:0] ef1, ef2;
        int n;
        do_reset();
        model(2'd0, 8'h7F, 8'h01, er1, ef1);
        model(2'd1, 8'h10, 8'h20, er2, ef2);
        req_valid = 1'b1; req_op = 2'd0; req_a = 8'h7F; req_b = 8'h01;
        @(posedge clk); @(negedge clk);
        req_op = 2'd1; req_a = 8'h10; req_b = 8'h20; resp_ready = 1'b1;
        n = 1;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (resp_result !== er1 || resp_flags !== ef1 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first: result=%h flags=%b rdy=%b want %h %b 1", resp_result, resp_flags, req_ready, er1, ef1);
        end
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || busy !== 1'b1 || alu_a !== 8'h10 || alu_b !== 8'h20 || alu_op !== 2'd1) begin
            miscompares++;
            $display("FAIL b2b_accept: vld=%b busy=%b a=%h b=%h op=%0d want 0 1 10 20 1", resp_valid, busy, alu_a, alu_b, alu_op);
        end
        n = 1;
        while (!resp_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
        vectors++;
        if (n !== LAT + 2 || resp_result !== er2 || resp_flags !== ef2) begin
            miscompares++;
            $display("FAIL b2b_second: cycles=%0d result=%h flags=%b want %0d %h %b", n, resp_result, resp_flags, LAT + 2, er2, ef2);
        end
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle: vld=%b busy=%b want 0 0", resp_valid, busy);
        end
`ifdef ALU_ISSUE_PERF_EN
        vectors++;
        if (perf_ops !== 16'd2) begin
            miscompares++; $display("FAIL b2b_perf_ops: %0d want 2", perf_ops);
        end
`endif
    endtask

    task automatic test_reset_mid_op();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd3; req_a = 8'h5A; req_b = 8'hA5; resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h00 ||
            alu_op !== 2'd0 || resp_result !== 8'h00 || resp_flags !== 3'b000) begin
            miscompares++;
            $display("FAIL midop_reset: busy=%b vld=%b a=%h b=%h op=%0d res=%h fl=%b", busy, resp_valid, alu_a, alu_b, alu_op, resp_result, resp_flags);
        end
        // The dropped op must never produce a response.
        n = 0;
        while (n < 8) begin
            vectors++;
            if (resp_valid !== 1'b0) begin
                miscompares++; $display("FAIL midop_ghost: resp_valid=%b want 0", resp_valid);
            end
            @(negedge clk); n++;
        end
        resp_ready = 1'b0;
        run_op(2'd0, 8'h01, 8'h01, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
